// File: rtl/button_mode_ctrl_if.sv
// Signal bundle between the board buttons / mode configuration and the
// push-button front end. The master side drives raw buttons, modes and clear;
// the slave side (the front end itself) returns debounced levels, event pulses
// and the per-channel control state.
interface button_mode_ctrl_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0]   btn_in;
   logic [2*N_CH-1:0] mode;
   logic              clr;
   logic [N_CH-1:0]   btn_db;
   logic [N_CH-1:0]   press_pulse;
   logic [N_CH-1:0]   release_pulse;
   logic [N_CH-1:0]   long_pulse;
   logic [N_CH-1:0]   state_out;

   modport master (
      output btn_in,
      output mode,
      output clr,
      input  btn_db,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse,
      input  state_out
   );

   modport slave (
      input  btn_in,
      input  mode,
      input  clr,
      output btn_db,
      output press_pulse,
      output release_pulse,
      output long_pulse,
      output state_out
   );
endinterface

// File: rtl/button_mode_ctrl.sv
// N-channel push-button front end. Each raw button is synchronised through two
// flops, debounced by requiring DEB_CYC consecutive stable samples, and then
// tracked by a press FSM (IDLE / PRESSED / LONG) that emits one-cycle press,
// release and long-press pulses. The per-channel mode decides how the state bit
// reacts to those events. Bit 0 is the pause/run control (1 = run).
module button_mode_ctrl #(
   parameter int              N_CH     = 4,
   parameter int              DEB_CYC  = 4,
   parameter int              LONG_CYC = 16,
   parameter logic [N_CH-1:0] RST_VAL  = {N_CH{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   button_mode_ctrl_if.slave bus
);

   localparam int DEB_W  = $clog2(DEB_CYC);
   localparam int HOLD_W = $clog2(LONG_CYC);

   // Last count value before a level is accepted / a press becomes long.
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

   localparam logic [1:0] MODE_TOGGLE    = 2'b00;
   localparam logic [1:0] MODE_TOG_PRESS = 2'b01;
   localparam logic [1:0] MODE_MOMENTARY = 2'b10;
   localparam logic [1:0] MODE_DISABLED  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PRESSED = 2'b01,
      ST_LONG    = 2'b10
   } press_state_t;

   // Synchroniser and debounce state
   logic [N_CH-1:0]   r_s1;
   logic [N_CH-1:0]   r_s2;
   logic [N_CH-1:0]   r_btn_db;
   logic [DEB_W-1:0]  r_deb_cnt [N_CH];

   // Press tracking state
   press_state_t      r_fsm     [N_CH];
   logic [HOLD_W-1:0] r_hold    [N_CH];
   // Set by clr while a button is still held: blocks a new press until the
   // debounced level has been seen low once.
   logic [N_CH-1:0]   r_wait_rel;

   // Registered outputs
   logic [N_CH-1:0]   r_press;
   logic [N_CH-1:0]   r_release;
   logic [N_CH-1:0]   r_long;
   logic [N_CH-1:0]   r_state;

   // Per-channel decoded mode and FSM transition events
   logic [1:0]        w_mode    [N_CH];
   logic [N_CH-1:0]   w_go_press;
   logic [N_CH-1:0]   w_go_short;
   logic [N_CH-1:0]   w_go_long;
   logic [N_CH-1:0]   w_go_lrel;

   // Slice the packed mode bus into one 2-bit field per channel.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         w_mode[i] = bus.mode[2*i +: 2];
      end
   end

   // Two-flop synchroniser for the asynchronous button inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1 <= {N_CH{1'b0}};
         r_s2 <= {N_CH{1'b0}};
      end else begin
         r_s1 <= bus.btn_in;
         r_s2 <= r_s1;
      end
   end

   // Debounce: accept the synchronised level once it has differed from the
   // current debounced level for DEB_CYC consecutive cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_btn_db <= {N_CH{1'b0}};
         for (int i = 0; i < N_CH; i++) begin
            r_deb_cnt[i] <= DEB_W'(0);
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (r_s2[i] == r_btn_db[i]) begin
               r_deb_cnt[i] <= DEB_W'(0);
            end else if (r_deb_cnt[i] == DEB_LAST) begin
               r_btn_db[i]  <= r_s2[i];
               r_deb_cnt[i] <= DEB_W'(0);
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
            end
         end
      end
   end

   // Decode which FSM transition each channel takes on the coming edge.
   // A release on the same edge the hold count expires is a short release.
   always_comb begin
      w_go_press = {N_CH{1'b0}};
      w_go_short = {N_CH{1'b0}};
      w_go_long  = {N_CH{1'b0}};
      w_go_lrel  = {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         case (r_fsm[i])
            ST_IDLE: begin
               if (r_btn_db[i] && !r_wait_rel[i]) begin
                  w_go_press[i] = 1'b1;
               end else begin
                  w_go_press[i] = 1'b0;
               end
            end
            ST_PRESSED: begin
               if (!r_btn_db[i]) begin
                  w_go_short[i] = 1'b1;
               end else if (r_hold[i] == HOLD_LAST) begin
                  w_go_long[i] = 1'b1;
               end else begin
                  w_go_short[i] = 1'b0;
               end
            end
            ST_LONG: begin
               if (!r_btn_db[i]) begin
                  w_go_lrel[i] = 1'b1;
               end else begin
                  w_go_lrel[i] = 1'b0;
               end
            end
            default: begin
               w_go_press[i] = 1'b0;
            end
         endcase
      end
   end

   // Press FSM, hold counter, event pulses and mode-dependent state bit.
   // clr restores the idle/clear picture but leaves debouncing untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_press    <= {N_CH{1'b0}};
         r_release  <= {N_CH{1'b0}};
         r_long     <= {N_CH{1'b0}};
         r_state    <= RST_VAL;
         r_wait_rel <= {N_CH{1'b0}};
         for (int i = 0; i < N_CH; i++) begin
            r_fsm[i]  <= ST_IDLE;
            r_hold[i] <= HOLD_W'(0);
         end
      end else if (bus.clr) begin
         r_press    <= {N_CH{1'b0}};
         r_release  <= {N_CH{1'b0}};
         r_long     <= {N_CH{1'b0}};
         r_state    <= RST_VAL;
         r_wait_rel <= r_btn_db;
         for (int i = 0; i < N_CH; i++) begin
            r_fsm[i]  <= ST_IDLE;
            r_hold[i] <= HOLD_W'(0);
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            // Pulses are suppressed on disabled channels; the FSM still runs.
            r_press[i]   <= w_go_press[i] & (w_mode[i] != MODE_DISABLED);
            r_release[i] <= (w_go_short[i] | w_go_lrel[i]) & (w_mode[i] != MODE_DISABLED);
            r_long[i]    <= w_go_long[i] & (w_mode[i] != MODE_DISABLED);

            case (r_fsm[i])
               ST_IDLE: begin
                  r_hold[i] <= HOLD_W'(0);
                  if (!r_btn_db[i]) begin
                     r_wait_rel[i] <= 1'b0;
                  end else begin
                     r_wait_rel[i] <= r_wait_rel[i];
                  end
                  if (w_go_press[i]) begin
                     r_fsm[i] <= ST_PRESSED;
                  end else begin
                     r_fsm[i] <= ST_IDLE;
                  end
               end
               ST_PRESSED: begin
                  if (w_go_short[i]) begin
                     r_fsm[i] <= ST_IDLE;
                  end else if (w_go_long[i]) begin
                     r_fsm[i] <= ST_LONG;
                  end else begin
                     r_hold[i] <= r_hold[i] + HOLD_W'(1);
                  end
               end
               ST_LONG: begin
                  if (w_go_lrel[i]) begin
                     r_fsm[i] <= ST_IDLE;
                  end else begin
                     r_fsm[i] <= ST_LONG;
                  end
               end
               default: begin
                  r_fsm[i]  <= ST_IDLE;
                  r_hold[i] <= HOLD_W'(0);
               end
            endcase

            case (w_mode[i])
               MODE_TOGGLE: begin
                  if (w_go_short[i]) begin
                     r_state[i] <= ~r_state[i];
                  end else if (w_go_long[i]) begin
                     r_state[i] <= RST_VAL[i];
                  end else begin
                     r_state[i] <= r_state[i];
                  end
               end
               MODE_TOG_PRESS: begin
                  if (w_go_press[i]) begin
                     r_state[i] <= ~r_state[i];
                  end else begin
                     r_state[i] <= r_state[i];
                  end
               end
               MODE_MOMENTARY: begin
                  r_state[i] <= r_btn_db[i];
               end
               default: begin
                  r_state[i] <= r_state[i];
               end
            endcase
         end
      end
   end

   assign bus.btn_db        = r_btn_db;
   assign bus.press_pulse   = r_press;
   assign bus.release_pulse = r_release;
   assign bus.long_pulse    = r_long;
   assign bus.state_out     = r_state;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Bench for button_mode_ctrl: directed scenarios plus a randomized run, all
// compared against a cycle-stepped behavioural model of the button rules.
module tb_button_mode_ctrl;
   localparam int         N    = 4;
   localparam int         DEB  = 4;
   localparam int         LONG = 16;
   localparam logic [3:0] RSTV = 4'b1111;

   logic clk = 1'b0;
   logic rst;

   button_mode_ctrl_if #(.N_CH(N)) bus ();

   button_mode_ctrl #(.N_CH(N), .DEB_CYC(DEB), .LONG_CYC(LONG), .RST_VAL(RSTV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- behavioural model ----------------
   // Per channel: synchroniser samples, length of the current disagreement run,
   // whether a press is in progress, its age in cycles and whether it went long.
   bit   m_s1 [N];
   bit   m_s2 [N];
   int   m_run [N];
   bit   m_held [N];
   int   m_age [N];
   bit   m_islong [N];
   bit   m_block [N];
   logic [3:0] e_db, e_p, e_r, e_l, e_st;

   function automatic void model_reset();
      for (int c = 0; c < N; c++) begin
         m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_run[c] = 0;
         m_held[c] = 1'b0; m_age[c] = 0; m_islong[c] = 1'b0; m_block[c] = 1'b0;
      end
      e_db = 4'b0000; e_p = 4'b0000; e_r = 4'b0000; e_l = 4'b0000; e_st = RSTV;
   endfunction

   function automatic void model_step(input logic [3:0] btn, input logic [7:0] md, input logic clr);
      for (int c = 0; c < N; c++) begin
         bit db_old;
         bit p, r, l, short_rel;
         int mode_c;
         db_old = e_db[c];
         p = 1'b0; r = 1'b0; l = 1'b0; short_rel = 1'b0;
         mode_c = int'(md[2*c +: 2]);
         // level accepted after DEB consecutive disagreeing samples
         if (m_s2[c] != db_old) begin
            m_run[c]++;
            if (m_run[c] == DEB) begin
               e_db[c]  = m_s2[c];
               m_run[c] = 0;
            end
         end else begin
            m_run[c] = 0;
         end
         m_s2[c] = m_s1[c];
         m_s1[c] = btn[c];
         if (clr) begin
            m_held[c] = 1'b0; m_islong[c] = 1'b0; m_age[c] = 0; m_block[c] = db_old;
            e_p[c] = 1'b0; e_r[c] = 1'b0; e_l[c] = 1'b0; e_st[c] = RSTV[c];
         end else begin
            if (!m_held[c]) begin
               if (db_old && !m_block[c]) begin
                  m_held[c] = 1'b1; m_age[c] = 0; p = 1'b1;
               end else if (!db_old) begin
                  m_block[c] = 1'b0;
               end
            end else if (!db_old) begin
               r = 1'b1; short_rel = !m_islong[c];
               m_held[c] = 1'b0; m_islong[c] = 1'b0;
            end else if (!m_islong[c]) begin
               m_age[c]++;
               if (m_age[c] == LONG) begin
                  m_islong[c] = 1'b1; l = 1'b1;
               end
            end
            case (mode_c)
               0: if (short_rel) e_st[c] = ~e_st[c]; else if (l) e_st[c] = RSTV[c];
               1: if (p) e_st[c] = ~e_st[c];
               2: e_st[c] = db_old;
               default: ;
            endcase
            e_p[c] = p && (mode_c != 3);
            e_r[c] = r && (mode_c != 3);
            e_l[c] = l && (mode_c != 3);
         end
      end
   endfunction

   function automatic logic [19:0] exp_vec();
      return {e_db, e_p, e_r, e_l, e_st};
   endfunction

   function automatic logic [19:0] obs_vec();
      return {bus.btn_db, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.state_out};
   endfunction

   // ---------------- stimulus helpers ----------------
   int obs_p [N];
   int obs_r [N];
   int obs_l [N];
   int bad_cycles;
   logic [19:0] bad_obs, bad_exp;

   task automatic clear_obs();
      for (int c = 0; c < N; c++) begin
         obs_p[c] = 0; obs_r[c] = 0; obs_l[c] = 0;
      end
      bad_cycles = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_reset();
      else model_step(bus.btn_in, bus.mode, bus.clr);
      #1;
   endtask

   // Advance n cycles, tallying observed pulses and model disagreements.
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         for (int c = 0; c < N; c++) begin
            obs_p[c] += int'(bus.press_pulse[c]);
            obs_r[c] += int'(bus.release_pulse[c]);
            obs_l[c] += int'(bus.long_pulse[c]);
         end
         if (obs_vec() !== exp_vec()) begin
            if (bad_cycles == 0) begin
               bad_obs = obs_vec();
               bad_exp = exp_vec();
            end
            bad_cycles++;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clear_obs();
      rst = 1'b0; bus.btn_in = 4'b1111; bus.mode = 8'h00; bus.clr = 1'b0;
      model_reset();
      #2;
      run(3);
      n_tests++;
      if (bus.state_out !== 4'b1111) begin
         n_fail++; $display("FAIL reset_state got %b expected %b", bus.state_out, 4'b1111);
      end
      n_tests++;
      if ({bus.btn_db, bus.press_pulse, bus.release_pulse, bus.long_pulse} !== 16'h0000) begin
         n_fail++; $display("FAIL reset_zero got %h expected 0000",
                            {bus.btn_db, bus.press_pulse, bus.release_pulse, bus.long_pulse});
      end
      bus.btn_in = 4'b0000;
      run(2);
      rst = 1'b1;
      run(4);
      n_tests++;
      if (bad_cycles != 0) begin
         n_fail++; $display("FAIL reset_model %0d cycles got %h expected %h", bad_cycles, bad_obs, bad_exp);
      end
   endtask

   task automatic test_toggle();
      clear_obs();
      bus.btn_in[0] = 1'b1;
      run(5);
      n_tests++;
      if (bus.btn_db[0] !== 1'b0) begin
         n_fail++; $display("FAIL toggle_db_early got %b expected 0", bus.btn_db[0]);
      end
      run(1);
      n_tests++;
      if (bus.btn_db[0] !== 1'b1) begin
         n_fail++; $display("FAIL toggle_db_edge6 got %b expected 1", bus.btn_db[0]);
      end
      run(4);
      n_tests++;
      if (obs_p[0] != 1 || bus.state_out[0] !== 1'b1) begin
         n_fail++; $display("FAIL toggle_press presses %0d state %b expected 1 and 1", obs_p[0], bus.state_out[0]);
      end
      bus.btn_in[0] = 1'b0;
      run(12);
      n_tests++;
      if (obs_r[0] != 1 || bus.state_out[0] !== 1'b0) begin
         n_fail++; $display("FAIL toggle_release releases %0d state %b expected 1 and 0", obs_r[0], bus.state_out[0]);
      end
      bus.btn_in[0] = 1'b1; run(10);
      bus.btn_in[0] = 1'b0; run(12);
      n_tests++;
      if (obs_p[0] != 2 || bus.state_out[0] !== 1'b1) begin
         n_fail++; $display("FAIL toggle_again presses %0d state %b expected 2 and 1", obs_p[0], bus.state_out[0]);
      end
      n_tests++;
      if (bad_cycles != 0) begin
         n_fail++; $display("FAIL toggle_model %0d cycles got %h expected %h", bad_cycles, bad_obs, bad_exp);
      end
   endtask

   task automatic test_glitch();
      clear_obs();
      bus.btn_in[0] = 1'b1; run(3);
      bus.btn_in[0] = 1'b0; run(10);
      n_tests++;
      if (obs_p[0] != 0 || bus.btn_db !== 4'b0000 || bus.state_out !== 4'b1111) begin
         n_fail++; $display("FAIL glitch presses %0d db %b state %b expected 0 0000 1111",
                            obs_p[0], bus.btn_db, bus.state_out);
      end
      n_tests++;
      if (bad_cycles != 0) begin
         n_fail++; $display("FAIL glitch_model %0d cycles got %h expected %h", bad_cycles, bad_obs, bad_exp);
      end
   endtask

   task automatic test_long();
      clear_obs();
      bus.btn_in[1] = 1'b1; run(8);
      bus.btn_in[1] = 1'b0; run(12);
      n_tests++;
      if (bus.state_out[1] !== 1'b0) begin
         n_fail++; $display("FAIL long_setup state %b expected 0", bus.state_out[1]);
      end
      clear_obs();
      bus.btn_in[1] = 1'b1; run(30);
      n_tests++;
      if (obs_l[1] != 1 || bus.state_out[1] !== 1'b1) begin
         n_fail++; $display("FAIL long_pulse longs %0d state %b expected 1 and 1", obs_l[1], bus.state_out[1]);
      end
      bus.btn_in[1] = 1'b0; run(12);
      n_tests++;
      if (obs_r[1] != 1 || bus.state_out[1] !== 1'b1) begin
         n_fail++; $display("FAIL long_release releases %0d state %b expected 1 and 1", obs_r[1], bus.state_out[1]);
      end
      n_tests++;
      if (bad_cycles != 0) begin
         n_fail++; $display("FAIL long_model %0d cycles got %h expected %h", bad_cycles, bad_obs, bad_exp);
      end
   endtask

   task automatic test_modes();
      clear_obs();
      bus.mode = 8'b10_01_00_00;
      run(2);
      n_tests++;
      if (bus.state_out[3] !== 1'b0) begin
         n_fail++; $display("FAIL mom_switch state %b expected 0", bus.state_out[3]);
      end
      bus.btn_in[3:2] = 2'b11;
      run(6);
      n_tests++;
      if (bus.btn_db[3] !== 1'b1 || bus.state_out[3] !== 1'b0) begin
         n_fail++; $display("FAIL mom_delay db %b state %b expected 1 and 0", bus.btn_db[3], bus.state_out[3]);
      end
      run(1);
      n_tests++;
      if (bus.state_out[3] !== 1'b1) begin
         n_fail++; $display("FAIL mom_follow state %b expected 1", bus.state_out[3]);
      end
      run(1);
      n_tests++;
      if (obs_p[2] != 1 || bus.state_out[2] !== 1'b0) begin
         n_fail++; $display("FAIL top_press presses %0d state %b expected 1 and 0", obs_p[2], bus.state_out[2]);
      end
      bus.btn_in[3:2] = 2'b00; run(12);
      n_tests++;
      if (bus.state_out[3:2] !== 2'b00 || obs_r[3] != 1) begin
         n_fail++; $display("FAIL modes_release state %b releases %0d expected 00 and 1", bus.state_out[3:2], obs_r[3]);
      end
      clear_obs();
      bus.mode = 8'b11_01_00_00;
      bus.btn_in[3] = 1'b1; run(30);
      bus.btn_in[3] = 1'b0; run(12);
      n_tests++;
      if (obs_p[3] + obs_r[3] + obs_l[3] != 0 || bus.state_out[3] !== 1'b0) begin
         n_fail++; $display("FAIL disabled pulses %0d state %b expected 0 and 0",
                            obs_p[3] + obs_r[3] + obs_l[3], bus.state_out[3]);
      end
      n_tests++;
      if (bad_cycles != 0) begin
         n_fail++; $display("FAIL modes_model %0d cycles got %h expected %h", bad_cycles, bad_obs, bad_exp);
      end
      bus.mode = 8'h00;
   endtask

   task automatic test_clr();
      clear_obs();
      bus.btn_in[0] = 1'b1; run(10);
      bus.btn_in[0] = 1'b0; run(6);
      bus.clr = 1'b1; run(1); bus.clr = 1'b0;
      n_tests++;
      if (obs_r[0] != 0 || bus.state_out[0] !== 1'b1) begin
         n_fail++; $display("FAIL clr_wins releases %0d state %b expected 0 and 1", obs_r[0], bus.state_out[0]);
      end
      run(6);
      bus.btn_in[1] = 1'b1; run(10);
      bus.clr = 1'b1; run(1); bus.clr = 1'b0;
      clear_obs();
      run(20);
      n_tests++;
      if (obs_p[1] != 0 || obs_l[1] != 0) begin
         n_fail++; $display("FAIL clr_held presses %0d longs %0d expected 0 and 0", obs_p[1], obs_l[1]);
      end
      bus.btn_in[1] = 1'b0; run(12);
      bus.btn_in[1] = 1'b1; run(10);
      n_tests++;
      if (obs_r[1] != 0 || obs_p[1] != 1) begin
         n_fail++; $display("FAIL clr_repress releases %0d presses %0d expected 0 and 1", obs_r[1], obs_p[1]);
      end
      bus.btn_in[1] = 1'b0; run(12);
      n_tests++;
      if (bad_cycles != 0) begin
         n_fail++; $display("FAIL clr_model %0d cycles got %h expected %h", bad_cycles, bad_obs, bad_exp);
      end
   endtask

   task automatic test_rst_mid();
      clear_obs();
      bus.btn_in[1] = 1'b1; run(10);
      rst = 1'b0;
      #2;
      n_tests++;
      if (obs_vec() !== {16'h0000, RSTV}) begin
         n_fail++; $display("FAIL rst_mid got %h expected %h", obs_vec(), {16'h0000, RSTV});
      end
      model_reset();
      run(2);
      rst = 1'b1;
      clear_obs();
      run(10);
      n_tests++;
      if (obs_p[1] != 1) begin
         n_fail++; $display("FAIL rst_redebounce presses %0d expected 1", obs_p[1]);
      end
      bus.btn_in[1] = 1'b0; run(12);
      n_tests++;
      if (bad_cycles != 0) begin
         n_fail++; $display("FAIL rst_model %0d cycles got %h expected %h", bad_cycles, bad_obs, bad_exp);
      end
   endtask

   task automatic test_random();
      int hold_left [N];
      for (int c = 0; c < N; c++) hold_left[c] = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int c = 0; c < N; c++) begin
            if (hold_left[c] == 0) begin
               bus.btn_in[c] = 1'($urandom_range(0, 1));
               hold_left[c]  = int'($urandom_range(1, 35));
            end else begin
               hold_left[c]--;
            end
         end
         if ($urandom_range(0, 199) == 0) bus.mode = 8'($urandom());
         bus.clr = ($urandom_range(0, 149) == 0);
         tick();
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cycle %0d got %h expected %h", cyc, obs_vec(), exp_vec());
         end
      end
      bus.clr = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      bus.btn_in = 4'b0000;
      bus.mode = 8'h00;
      bus.clr = 1'b0;
      test_reset();
      test_toggle();
      test_glitch();
      test_long();
      test_modes();
      test_clr();
      test_rst_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
